// File: rtl/huffman_encoder_packer_if.sv
// Symbol-in / packed-word-out bus of the Huffman encoder packer.
// master = symbol producer and word consumer, slave = the encoder.
// HENC_BITCNT_EN adds the delivered-bit counter output.
interface huffman_encoder_packer_if;
    logic [3:0]  symbolIn;
    logic        symbolValid;
    logic        symbolReady;
    logic        flush;
    logic [9:0]  encodedData;
    logic        load;
    logic        outReady;
    logic        lastWord;
    logic [3:0]  lastBits;
    logic        flushDone;
    logic        codeError;
`ifdef HENC_BITCNT_EN
    logic [15:0] totalBits;
`endif

    modport master (
        output symbolIn, symbolValid, flush, outReady,
        input  symbolReady, encodedData, load, lastWord, lastBits, flushDone, codeError
`ifdef HENC_BITCNT_EN
        , input totalBits
`endif
    );

    modport slave (
        input  symbolIn, symbolValid, flush, outReady,
        output symbolReady, encodedData, load, lastWord, lastBits, flushDone, codeError
`ifdef HENC_BITCNT_EN
        , output totalBits
`endif
    );
endinterface

// File: rtl/huffman_encoder_packer.sv
// Huffman encoder: maps 4-bit symbols to 1-6 bit prefix codes and packs them
// MSB-first into 10-bit words for the downstream decoder. A flush drains the
// residual partial word zero-padded.
// Optional macro HENC_BITCNT_EN adds the totalBits delivered-bit counter.
module huffman_encoder_packer #(
    parameter int WORD_W = 10,
    parameter int BUF_W  = 16
) (
    input  logic clk,
    input  logic rst,
    huffman_encoder_packer_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]        state;
    logic [BUF_W-1:0]  buffer;
    logic [4:0]        bit_count;
    logic [WORD_W-1:0] word_reg;
    logic              load_reg;
    logic              last_word;
    logic [3:0]        last_bits;
    logic              flush_done;
    logic              code_error;
    logic [5:0]        code_bits;
    logic [2:0]        code_len;
    logic              code_ok;
    logic [BUF_W-1:0]  aligned;
    logic              accept;
    logic              handshake;

    // Code table: codes are stored left-justified in a 6-bit field.
    always_comb begin
        code_bits = 6'b000000;
        code_len  = 3'd0;
        code_ok   = 1'b1;
        case (bus.symbolIn)
            4'd0:    begin code_bits = 6'b100000; code_len = 3'd1; end
            4'd1:    begin code_bits = 6'b010000; code_len = 3'd4; end
            4'd2:    begin code_bits = 6'b010100; code_len = 3'd4; end
            4'd5:    begin code_bits = 6'b001000; code_len = 3'd4; end
            4'd6:    begin code_bits = 6'b001100; code_len = 3'd4; end
            4'd9:    begin code_bits = 6'b011100; code_len = 3'd4; end
            4'd10:   begin code_bits = 6'b000000; code_len = 3'd4; end
            4'd7:    begin code_bits = 6'b011010; code_len = 3'd5; end
            4'd3:    begin code_bits = 6'b011000; code_len = 3'd6; end
            4'd4:    begin code_bits = 6'b011001; code_len = 3'd6; end
            4'd8:    begin code_bits = 6'b000110; code_len = 3'd6; end
            4'd12:   begin code_bits = 6'b000111; code_len = 3'd6; end
            4'd14:   begin code_bits = 6'b000100; code_len = 3'd6; end
            4'd15:   begin code_bits = 6'b000101; code_len = 3'd6; end
            default: code_ok = 1'b0;
        endcase
    end

    assign aligned   = {code_bits, {(BUF_W-6){1'b0}}} >> bit_count;
    assign accept    = bus.symbolValid && bus.symbolReady;
    assign handshake = load_reg && bus.outReady;

    assign bus.symbolReady = (state == ST_RUN) && (bit_count < 5'd10) && !load_reg;
    assign bus.encodedData = word_reg;
    assign bus.load        = load_reg;
    assign bus.lastWord    = last_word;
    assign bus.lastBits    = last_bits;
    assign bus.flushDone   = flush_done;
    assign bus.codeError   = code_error;

    // Main packer: accept/append, word emission, consumer handshake and flush drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            buffer     <= '0;
            bit_count  <= 5'd0;
            word_reg   <= '0;
            load_reg   <= 1'b0;
            last_word  <= 1'b0;
            last_bits  <= 4'd0;
            flush_done <= 1'b0;
            code_error <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            code_error <= 1'b0;
            if (handshake) begin
                load_reg <= 1'b0;
                if (last_word) begin
                    buffer     <= '0;
                    bit_count  <= 5'd0;
                    last_word  <= 1'b0;
                    flush_done <= 1'b1;
                    state      <= ST_RUN;
                end else begin
                    buffer    <= buffer << WORD_W;
                    bit_count <= bit_count - 5'd10;
                end
            end else if (!load_reg) begin
                if (state == ST_RUN) begin
                    if (accept) begin
                        if (code_ok) begin
                            buffer    <= buffer | aligned;
                            bit_count <= bit_count + {2'b00, code_len};
                        end else begin
                            code_error <= 1'b1;
                        end
                    end
                    if (bit_count >= 5'd10) begin
                        word_reg  <= buffer[BUF_W-1 -: WORD_W];
                        load_reg  <= 1'b1;
                        last_word <= 1'b0;
                    end
                    if (bus.flush) begin
                        state <= ST_FLUSH;
                    end
                end else begin
                    if (bit_count > 5'd10) begin
                        word_reg  <= buffer[BUF_W-1 -: WORD_W];
                        load_reg  <= 1'b1;
                        last_word <= 1'b0;
                    end else if (bit_count != 5'd0) begin
                        word_reg  <= buffer[BUF_W-1 -: WORD_W];
                        load_reg  <= 1'b1;
                        last_word <= 1'b1;
                        last_bits <= bit_count[3:0];
                    end else begin
                        flush_done <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
            end else if ((state == ST_RUN) && bus.flush) begin
                state <= ST_FLUSH;
            end
        end
    end

`ifdef HENC_BITCNT_EN
    logic [15:0] total_bits;

    // Count code bits actually handed to the consumer; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_bits <= 16'd0;
        end else if (handshake) begin
            total_bits <= total_bits + (last_word ? {12'd0, last_bits} : 16'd10);
        end
    end

    assign bus.totalBits = total_bits;
`endif
endmodule

// File: tb/tb_huffman_encoder_packer.sv
// Directed testbench for huffman_encoder_packer with hand-computed words.
module tb_huffman_encoder_packer;
    logic clk;
    logic rst;
    int   vector_count;
    int   miss_count;

    huffman_encoder_packer_if bus();

    huffman_encoder_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log misses.
    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle 1 ns past the rising edge.
    task automatic applyStimulus(input logic [3:0] sym, input logic valid,
                                 input logic flush_req, input logic ready_out);
        bus.symbolIn    = sym;
        bus.symbolValid = valid;
        bus.flush       = flush_req;
        bus.outReady    = ready_out;
        @(posedge clk);
        #1;
        bus.symbolValid = 1'b0;
        bus.flush       = 1'b0;
    endtask

    initial begin
        vector_count    = 0;
        miss_count      = 0;
        rst             = 1'b0;
        bus.symbolIn    = 4'd0;
        bus.symbolValid = 1'b0;
        bus.flush       = 1'b0;
        bus.outReady    = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_data",  16'(bus.encodedData), 16'h000);
        checkOutput("rst_load",  16'(bus.load), 16'd0);
        checkOutput("rst_last",  16'(bus.lastWord), 16'd0);
        checkOutput("rst_bits",  16'(bus.lastBits), 16'd0);
        checkOutput("rst_fdone", 16'(bus.flushDone), 16'd0);
        checkOutput("rst_cerr",  16'(bus.codeError), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("rst_ready", 16'(bus.symbolReady), 16'd1);

        // Ten one-bit codes fill exactly one word
        for (int i = 0; i < 10; i++) applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("a_load_early", 16'(bus.load), 16'd0);
        checkOutput("a_ready_full", 16'(bus.symbolReady), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("a_load", 16'(bus.load), 16'd1);
        checkOutput("a_data", 16'(bus.encodedData), 16'h3FF);
        checkOutput("a_lastw", 16'(bus.lastWord), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("a_load_drop", 16'(bus.load), 16'd0);
        checkOutput("a_ready_back", 16'(bus.symbolReady), 16'd1);

        // 7,7 -> 01101_01101 ; 3,9 -> 011000_0111
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("b77_load", 16'(bus.load), 16'd1);
        checkOutput("b77_data", 16'(bus.encodedData), 16'h1AD);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd9, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("b39_load", 16'(bus.load), 16'd1);
        checkOutput("b39_data", 16'(bus.encodedData), 16'h187);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("b39_drop", 16'(bus.load), 16'd0);

        // Single bit then flush -> padded last word of one valid bit
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("c_ready_flush", 16'(bus.symbolReady), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("c_load", 16'(bus.load), 16'd1);
        checkOutput("c_data", 16'(bus.encodedData), 16'h200);
        checkOutput("c_lastw", 16'(bus.lastWord), 16'd1);
        checkOutput("c_lastb", 16'(bus.lastBits), 16'd1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("c_fdone", 16'(bus.flushDone), 16'd1);
        checkOutput("c_load_drop", 16'(bus.load), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("c_fdone_pulse", 16'(bus.flushDone), 16'd0);

        // Flush on an empty buffer -> flushDone only
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("c0_fdone_early", 16'(bus.flushDone), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("c0_fdone", 16'(bus.flushDone), 16'd1);
        checkOutput("c0_noload", 16'(bus.load), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("c0_fdone_pulse", 16'(bus.flushDone), 16'd0);
        checkOutput("c0_ready", 16'(bus.symbolReady), 16'd1);

        // Unsupported symbol adds no bits
        applyStimulus(4'd11, 1'b1, 1'b0, 1'b1);
        checkOutput("d_cerr", 16'(bus.codeError), 16'd1);
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("d_cerr_pulse", 16'(bus.codeError), 16'd0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("d_data", 16'(bus.encodedData), 16'h200);
        checkOutput("d_lastb", 16'(bus.lastBits), 16'd1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("d_fdone", 16'(bus.flushDone), 16'd1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);

        // Backpressure: word must hold while outReady is low
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("e_load", 16'(bus.load), 16'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
            checkOutput("e_hold_data", 16'(bus.encodedData), 16'h1AD);
            checkOutput("e_hold_load", 16'(bus.load), 16'd1);
            checkOutput("e_hold_ready", 16'(bus.symbolReady), 16'd0);
        end
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("e_consumed", 16'(bus.load), 16'd0);
        checkOutput("e_ready", 16'(bus.symbolReady), 16'd1);

        // 3,4 -> word 011000_0110 with residual 01, then flushed
        applyStimulus(4'd3, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd4, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("f_data", 16'(bus.encodedData), 16'h186);
        checkOutput("f_load", 16'(bus.load), 16'd1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("f_ready_resid", 16'(bus.symbolReady), 16'd1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("f_last_data", 16'(bus.encodedData), 16'h100);
        checkOutput("f_lastw", 16'(bus.lastWord), 16'd1);
        checkOutput("f_lastb", 16'(bus.lastBits), 16'd2);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("f_fdone", 16'(bus.flushDone), 16'd1);

        // Asynchronous reset with seven bits pending
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("g_rst_data", 16'(bus.encodedData), 16'h000);
        checkOutput("g_rst_load", 16'(bus.load), 16'd0);
        checkOutput("g_rst_lastb", 16'(bus.lastBits), 16'd0);
        checkOutput("g_rst_fdone", 16'(bus.flushDone), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("g_ready", 16'(bus.symbolReady), 16'd1);
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd7, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("g_load", 16'(bus.load), 16'd1);
        checkOutput("g_data", 16'(bus.encodedData), 16'h1AD);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end
endmodule

// File: doc/huffman_encoder_packer.md
Name: huffman_encoder_packer

Overview:
- Upstream neighbour of the Huffman decoder.
- Accepts one 4-bit symbol per handshake and looks up its variable-length prefix code (1-6 bits) in a fixed table.
- Packs codes MSB-first into 10-bit words and presents each full word with a load strobe, so its outputs drive the decoder's encodedData/load inputs directly.
- A flush request drains the residual partial word, zero-padded.

Parameters:
- WORD_W, 10, output word width; fixed at 10 to match the decoder window; other values unsupported.
- BUF_W, 16, internal bit-buffer width; must be >= WORD_W+6-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- symbolIn  input  4  symbol to encode
- symbolValid  input  1  symbolIn valid
- symbolReady  output  1  encoder can accept symbol this cycle (combinational)
- flush  input  1  request drain of residual bits (single-cycle pulse)
- encodedData  output  10  packed code word; first code bit in bit 9
- load  output  1  encodedData valid
- outReady  input  1  consumer accepts word when high with load
- lastWord  output  1  qualifies load: final word of a flush
- lastBits  output  4  valid bits in final word (1-10); meaningful only when lastWord=1
- flushDone  output  1  one-cycle pulse: flush complete
- codeError  output  1  one-cycle pulse: unsupported symbol accepted

Behaviour:
- Code table (symbol: code):
  - 0: 1
  - 1: 0100, 2: 0101, 5: 0010, 6: 0011, 9: 0111, 10: 0000
  - 7: 01101
  - 3: 011000, 4: 011001, 8: 000110, 12: 000111, 14: 000100, 15: 000101
  - 11 and 13 unsupported.
- Reset (rst=0, async):
  - bit buffer = 0, bitCount = 0, state = RUN.
  - encodedData = 0; load, lastWord, flushDone, codeError = 0; lastBits = 0.
  - Partial bits are discarded and a pending word is dropped.
- Invariant: buffer bits below the valid bitCount are always 0, so padding is implicit.
- States:
  - RUN: symbolReady = (bitCount < 10) && !load.
  - FLUSH: symbolReady = 0.
- Accept: symbolValid && symbolReady at a clock edge.
  - Append code at position bitCount (MSB-aligned); bitCount += length.
  - Unsupported symbol: handshake completes, no bits appended, codeError=1 next cycle.
- Emit, RUN:
  - When bitCount >= 10 and !load: register encodedData = buffer[15:6], load=1, lastWord=0.
  - Latency: load rises the cycle after the accept that pushes bitCount to >= 10.
- Handshake:
  - load and encodedData hold stable until sampled with outReady=1.
  - At that edge: buffer shifts left 10, bitCount -= 10, load drops (or re-asserts next cycle if still >= 10).
  - outReady while load=0 is ignored.
- Flush:
  - flush sampled in RUN moves the block to FLUSH.
  - A symbol accepted on the same edge is included.
  - flush while in FLUSH is ignored.
- FLUSH per cycle (once any pending word has completed):
  - bitCount > 10: emit full word, lastWord=0.
  - 1 <= bitCount <= 10: emit buffer[15:6] with lastWord=1 and lastBits=bitCount; flushDone pulses on the edge this word is accepted; bitCount=0; return to RUN.
  - bitCount == 0 at entry or after a handshake: flushDone pulses one cycle, no load, return to RUN.
- Max bitCount = 9+6 = 15; no overflow possible.
- The consumer may hold outReady low indefinitely; no data loss.

Optional Feature:
- Macro HENC_BITCNT_EN.
- Defined:
  - Adds output totalBits [15:0]: count of valid code bits delivered (full words count 10; last word counts lastBits).
  - Updated on each load&&outReady handshake; wraps at 65535->0; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Ten accepts of symbol 0, outReady=1 -> one load with encodedData=10'b1111111111 the cycle after the 10th accept; bitCount 0.
- Symbols 7, 7 -> encodedData=10'b0110101101, load=1; symbols 3, 9 -> encodedData=10'b0110000111.
- Symbol 0 then flush -> load with encodedData=10'b1000000000, lastWord=1, lastBits=1, flushDone=1; flush on an empty buffer -> flushDone pulse, no load.
- Symbol 11 accepted -> codeError=1 for one cycle, no bits added; next symbol 0 is packed at bit 9.
- outReady=0 for 5 cycles while load=1 -> encodedData stable, symbolReady=0; outReady=1 -> word consumed, symbolReady returns.
- rst low mid-word (bitCount=7) -> all outputs 0 immediately, symbolReady=1 after release, next word contains only post-reset codes.
